// File: rtl/uart_pkt_rx.sv
// uart_pkt_rx: deframes SYNC/CMD/LEN/PAYLOAD/CSUM packets from a UART byte stream.
// Optional mid-frame idle timeout is enabled by defining UART_PKT_TIMEOUT_EN.
module uart_pkt_rx #(
    parameter int          MAX_LEN     = 64,
    parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
    parameter int          TIMEOUT_CYC = 26040,
    localparam int         AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          pkt_valid,
    input  logic          pkt_ack,
    output logic [7:0]    pkt_cmd,
    output logic [7:0]    pkt_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [15:0]   err_csum_cnt,
    output logic [15:0]   err_len_cnt,
    output logic [15:0]   err_to_cnt,
    output logic [15:0]   drop_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PAY, S_CSUM, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [7:0]  sum_q, sum_d, cmd_q, cmd_d, len_q, len_d, idx_q, idx_d, rd_data_q, rd_data_d;
    logic        pkt_valid_q, pkt_valid_d;
    logic [15:0] csum_cnt_q, csum_cnt_d, len_cnt_q, len_cnt_d, drop_cnt_q, drop_cnt_d;
    logic [7:0]  mem_q [2**AW];
    logic        to_hit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef UART_PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [15:0]   to_err_q, to_err_d;
    logic          frame_active;

    // idle-cycle watchdog, armed only while a frame is partially received
    always_comb begin
        frame_active = state_q inside {S_CMD, S_LEN, S_PAY, S_CSUM};
        to_hit       = frame_active && !rx_valid && (to_cnt_q == TW'(TIMEOUT_CYC - 1));
        to_cnt_d     = (!frame_active || rx_valid || to_hit) ? '0 : to_cnt_q + TW'(1);
        to_err_d     = to_hit ? sat_inc(to_err_q) : to_err_q;
    end

    // watchdog registers
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            to_err_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign err_to_cnt = to_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYC;
    assign to_hit         = 1'b0;
    assign err_to_cnt     = 16'd0;
`endif

    // state register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // next-state logic; a watchdog expiry abandons the partial frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state_d = S_CMD;
            S_CMD:  if (rx_valid) state_d = S_LEN;
            S_LEN:  if (rx_valid) state_d = (rx_data > 8'(MAX_LEN)) ? S_IDLE :
                                            (rx_data == 8'd0)       ? S_CSUM : S_PAY;
            S_PAY:  if (rx_valid && idx_q == len_q - 8'd1) state_d = S_CSUM;
            S_CSUM: if (rx_valid) state_d = (rx_data == sum_q) ? S_HOLD : S_IDLE;
            S_HOLD: if (pkt_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (to_hit) state_d = S_IDLE;
    end

    // datapath and counter updates driven by the current state
    always_comb begin
        cmd_d       = (state_q == S_CMD && rx_valid) ? rx_data : cmd_q;
        len_d       = (state_q == S_LEN && rx_valid) ? rx_data : len_q;
        idx_d       = (state_q == S_LEN) ? 8'd0 : (state_q == S_PAY && rx_valid) ? idx_q + 8'd1 : idx_q;
        sum_d       = (state_q == S_IDLE) ? SYNC_BYTE :
                      (rx_valid && state_q inside {S_CMD, S_LEN, S_PAY}) ? sum_q + rx_data : sum_q;
        pkt_valid_d = (state_d == S_HOLD);
        csum_cnt_d  = (state_q == S_CSUM && rx_valid && rx_data != sum_q) ? sat_inc(csum_cnt_q) : csum_cnt_q;
        len_cnt_d   = (state_q == S_LEN && rx_valid && rx_data > 8'(MAX_LEN)) ? sat_inc(len_cnt_q) : len_cnt_q;
        drop_cnt_d  = (state_q == S_HOLD && rx_valid) ? sat_inc(drop_cnt_q) : drop_cnt_q;
        rd_data_d   = mem_q[rd_addr];
    end

    // output and bookkeeping registers
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            cmd_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            rd_data_q   <= '0;
            pkt_valid_q <= 1'b0;
            csum_cnt_q  <= '0;
            len_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            sum_q       <= sum_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            rd_data_q   <= rd_data_d;
            pkt_valid_q <= pkt_valid_d;
            csum_cnt_q  <= csum_cnt_d;
            len_cnt_q   <= len_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // payload buffer, written only while collecting payload bytes
    always_ff @(posedge CLK) begin
        if (state_q == S_PAY && rx_valid) mem_q[idx_q[AW-1:0]] <= rx_data;
    end

    assign pkt_valid    = pkt_valid_q;
    assign pkt_cmd      = cmd_q;
    assign pkt_len      = len_q;
    assign rd_data      = rd_data_q;
    assign err_csum_cnt = csum_cnt_q;
    assign err_len_cnt  = len_cnt_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_uart_pkt_rx.sv
// tb_uart_pkt_rx: randomized self-checking bench for uart_pkt_rx against a frame-level model.
module tb_uart_pkt_rx;

    localparam int MAX_LEN     = 64;
    localparam int TIMEOUT_CYC = 26040;
    localparam int AW          = $clog2(MAX_LEN);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          pkt_ack = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          pkt_valid;
    logic [7:0]    pkt_cmd, pkt_len, rd_data;
    logic [15:0]   err_csum_cnt, err_len_cnt, err_to_cnt, drop_cnt;

    int ntot = 0;
    int npass = 0;
    logic [7:0]  pl [256];
    logic [15:0] exp_csum = 0, exp_len = 0, exp_drop = 0, exp_to = 0;

    uart_pkt_rx #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hAA), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .CLK(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .pkt_valid(pkt_valid), .pkt_ack(pkt_ack), .pkt_cmd(pkt_cmd), .pkt_len(pkt_len),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .err_csum_cnt(err_csum_cnt), .err_len_cnt(err_len_cnt),
        .err_to_cnt(err_to_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // one byte strobe, preceded by a random idle gap; returns on the negedge after the strobe
    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // whole frame from pl[]; checksum is the mod-256 sum of every preceding byte
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len, input bit bad);
        logic [7:0] s;
        s = 8'hAA + cmd + len;
        send_byte(8'hAA);
        send_byte(cmd);
        send_byte(len);
        for (int i = 0; i < int'(len); i++) begin
            send_byte(pl[i]);
            s = s + pl[i];
        end
        send_byte(bad ? s + 8'd1 : s);
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 16; i++) pl[i] = 8'(8'h10 + i);
    endtask

    task automatic do_ack();
        pkt_ack = 1'b1;
        @(negedge clk);
        pkt_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        ntot++; if (pkt_valid !== 1'b0) $display("FAIL reset_valid got %h exp 0", pkt_valid); else npass++;
        ntot++; if (pkt_cmd !== 8'd0) $display("FAIL reset_cmd got %h exp 00", pkt_cmd); else npass++;
        ntot++; if (pkt_len !== 8'd0) $display("FAIL reset_len got %h exp 00", pkt_len); else npass++;
        ntot++; if (rd_data !== 8'd0) $display("FAIL reset_rd_data got %h exp 00", rd_data); else npass++;
        ntot++; if (err_csum_cnt !== 16'd0) $display("FAIL reset_csum_cnt got %h exp 0", err_csum_cnt); else npass++;
        ntot++; if (err_len_cnt !== 16'd0) $display("FAIL reset_len_cnt got %h exp 0", err_len_cnt); else npass++;
        ntot++; if (err_to_cnt !== 16'd0) $display("FAIL reset_to_cnt got %h exp 0", err_to_cnt); else npass++;
        ntot++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt got %h exp 0", drop_cnt); else npass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_spec_vectors();
        fill_ramp();
        send_frame(8'h01, 8'd16, 1'b0);
        ntot++; if (pkt_valid !== 1'b1) $display("FAIL good_valid got %h exp 1", pkt_valid); else npass++;
        ntot++; if (pkt_cmd !== 8'h01) $display("FAIL good_cmd got %h exp 01", pkt_cmd); else npass++;
        ntot++; if (pkt_len !== 8'd16) $display("FAIL good_len got %h exp 10", pkt_len); else npass++;
        for (int i = 0; i < 16; i++) begin
            rd_addr = AW'(i);
            @(negedge clk);
            ntot++; if (rd_data !== 8'(8'h10 + i)) $display("FAIL good_payload[%0d] got %h exp %h", i, rd_data, 8'(8'h10 + i)); else npass++;
        end
        ntot++; if (err_csum_cnt !== 16'd0 || err_len_cnt !== 16'd0 || drop_cnt !== 16'd0)
            $display("FAIL good_err_cnts got %h/%h/%h exp 0/0/0", err_csum_cnt, err_len_cnt, drop_cnt); else npass++;
        do_ack();
        ntot++; if (pkt_valid !== 1'b0) $display("FAIL good_ack got %h exp 0", pkt_valid); else npass++;
        send_frame(8'h05, 8'd0, 1'b0);
        ntot++; if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h05 || pkt_len !== 8'd0)
            $display("FAIL zero_len got v=%h c=%h l=%h exp v=1 c=05 l=00", pkt_valid, pkt_cmd, pkt_len); else npass++;
        do_ack();
    endtask

    task automatic test_bad_csum();
        logic [7:0] len;
        len = 8'($urandom_range(1, MAX_LEN));
        fill_random(int'(len));
        send_frame(8'($urandom), len, 1'b1);
        exp_csum++;
        repeat (2) @(negedge clk);
        ntot++; if (pkt_valid !== 1'b0) $display("FAIL bad_csum_valid got %h exp 0", pkt_valid); else npass++;
        ntot++; if (err_csum_cnt !== exp_csum) $display("FAIL bad_csum_cnt got %h exp %h", err_csum_cnt, exp_csum); else npass++;
        fill_ramp();
        send_frame(8'h01, 8'd16, 1'b0);
        ntot++; if (pkt_valid !== 1'b1 || pkt_len !== 8'd16) $display("FAIL after_bad_csum got v=%h l=%h exp v=1 l=10", pkt_valid, pkt_len); else npass++;
        do_ack();
    endtask

    task automatic test_over_len();
        send_byte(8'hAA);
        send_byte(8'h02);
        send_byte(8'h41);
        exp_len++;
        ntot++; if (err_len_cnt !== exp_len) $display("FAIL over_len_cnt got %h exp %h", err_len_cnt, exp_len); else npass++;
        send_frame(8'h05, 8'd0, 1'b0);
        ntot++; if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h05) $display("FAIL after_over_len got v=%h c=%h exp v=1 c=05", pkt_valid, pkt_cmd); else npass++;
        do_ack();
        send_byte(8'hAA);
        send_byte(8'h07);
        send_byte(8'($urandom_range(MAX_LEN + 1, 255)));
        exp_len++;
        ntot++; if (err_len_cnt !== exp_len || pkt_valid !== 1'b0) $display("FAIL over_len_rand got cnt=%h v=%h exp cnt=%h v=0", err_len_cnt, pkt_valid, exp_len); else npass++;
        fill_random(MAX_LEN);
        send_frame(8'h09, 8'(MAX_LEN), 1'b0);
        ntot++; if (pkt_valid !== 1'b1 || pkt_len !== 8'(MAX_LEN)) $display("FAIL max_len got v=%h l=%h exp v=1 l=%h", pkt_valid, pkt_len, 8'(MAX_LEN)); else npass++;
        rd_addr = AW'(MAX_LEN - 1);
        @(negedge clk);
        ntot++; if (rd_data !== pl[MAX_LEN-1]) $display("FAIL max_len_last got %h exp %h", rd_data, pl[MAX_LEN-1]); else npass++;
        ntot++; if (err_len_cnt !== exp_len) $display("FAIL max_len_cnt got %h exp %h", err_len_cnt, exp_len); else npass++;
        do_ack();
    endtask

    task automatic test_hold_drop();
        fill_random(8);
        send_frame(8'h3C, 8'd8, 1'b0);
        send_byte(8'hAA);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        exp_drop += 5;
        ntot++; if (drop_cnt !== exp_drop) $display("FAIL hold_drop_cnt got %h exp %h", drop_cnt, exp_drop); else npass++;
        ntot++; if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h3C || pkt_len !== 8'd8)
            $display("FAIL hold_stable got v=%h c=%h l=%h exp v=1 c=3c l=08", pkt_valid, pkt_cmd, pkt_len); else npass++;
        for (int i = 0; i < 8; i++) begin
            rd_addr = AW'(i);
            @(negedge clk);
            ntot++; if (rd_data !== pl[i]) $display("FAIL hold_payload[%0d] got %h exp %h", i, rd_data, pl[i]); else npass++;
        end
        pkt_ack  = 1'b1;
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        @(negedge clk);
        pkt_ack  = 1'b0;
        rx_valid = 1'b0;
        exp_drop++;
        ntot++; if (drop_cnt !== exp_drop || pkt_valid !== 1'b0) $display("FAIL ack_cycle_drop got cnt=%h v=%h exp cnt=%h v=0", drop_cnt, pkt_valid, exp_drop); else npass++;
        do_ack();
        ntot++; if (pkt_valid !== 1'b0) $display("FAIL ack_idle_ignored got %h exp 0", pkt_valid); else npass++;
        fill_ramp();
        send_frame(8'h01, 8'd16, 1'b0);
        ntot++; if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h01) $display("FAIL after_hold got v=%h c=%h exp v=1 c=01", pkt_valid, pkt_cmd); else npass++;
        do_ack();
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 25; n++) begin
            logic [7:0] cmd, len;
            bit         bad;
            int         extra;
            cmd = 8'($urandom);
            len = 8'($urandom_range(0, MAX_LEN));
            bad = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 3)) send_byte(8'($urandom_range(0, 8'hA9)));
            fill_random(int'(len));
            send_frame(cmd, len, bad);
            if (bad) begin
                exp_csum++;
                ntot++; if (pkt_valid !== 1'b0) $display("FAIL rand%0d_bad_valid got %h exp 0", n, pkt_valid); else npass++;
            end else begin
                ntot++; if (pkt_valid !== 1'b1 || pkt_cmd !== cmd || pkt_len !== len)
                    $display("FAIL rand%0d_hdr got v=%h c=%h l=%h exp v=1 c=%h l=%h", n, pkt_valid, pkt_cmd, pkt_len, cmd, len); else npass++;
                for (int i = 0; i < int'(len); i++) begin
                    rd_addr = AW'(i);
                    @(negedge clk);
                    ntot++; if (rd_data !== pl[i]) $display("FAIL rand%0d_payload[%0d] got %h exp %h", n, i, rd_data, pl[i]); else npass++;
                end
                extra = $urandom_range(0, 2);
                repeat (extra) send_byte(8'($urandom));
                exp_drop += 16'(extra);
                do_ack();
            end
            ntot++; if (err_csum_cnt !== exp_csum || err_len_cnt !== exp_len || drop_cnt !== exp_drop)
                $display("FAIL rand%0d_cnts got %h/%h/%h exp %h/%h/%h", n, err_csum_cnt, err_len_cnt, drop_cnt, exp_csum, exp_len, exp_drop); else npass++;
        end
    endtask

    task automatic test_timeout();
        fill_ramp();
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h10);
        for (int i = 0; i < 4; i++) send_byte(pl[i]);
`ifdef UART_PKT_TIMEOUT_EN
        repeat (TIMEOUT_CYC - 10) @(negedge clk);
        ntot++; if (err_to_cnt !== exp_to) $display("FAIL timeout_early got %h exp %h", err_to_cnt, exp_to); else npass++;
        repeat (20) @(negedge clk);
        exp_to++;
        ntot++; if (err_to_cnt !== exp_to) $display("FAIL timeout_cnt got %h exp %h", err_to_cnt, exp_to); else npass++;
        send_frame(8'h01, 8'd16, 1'b0);
`else
        repeat (3000) @(negedge clk);
        for (int i = 4; i < 16; i++) send_byte(pl[i]);
        send_byte(8'h33);
`endif
        ntot++; if (pkt_valid !== 1'b1 || pkt_len !== 8'd16) $display("FAIL after_stall got v=%h l=%h exp v=1 l=10", pkt_valid, pkt_len); else npass++;
        ntot++; if (err_to_cnt !== exp_to) $display("FAIL stall_to_cnt got %h exp %h", err_to_cnt, exp_to); else npass++;
        do_ack();
    endtask

    task automatic test_reset_mid();
        fill_random(8);
        send_byte(8'hAA);
        send_byte(8'h03);
        send_byte(8'h08);
        for (int i = 0; i < 3; i++) send_byte(pl[i]);
        #2 rst = 1'b1;
        #1;
        exp_csum = 0; exp_len = 0; exp_drop = 0; exp_to = 0;
        ntot++; if (pkt_valid !== 1'b0 || pkt_cmd !== 8'd0 || pkt_len !== 8'd0 || rd_data !== 8'd0)
            $display("FAIL midrst_out got v=%h c=%h l=%h d=%h exp all 0", pkt_valid, pkt_cmd, pkt_len, rd_data); else npass++;
        ntot++; if (err_csum_cnt !== 16'd0 || err_len_cnt !== 16'd0 || err_to_cnt !== 16'd0 || drop_cnt !== 16'd0)
            $display("FAIL midrst_cnts got %h/%h/%h/%h exp all 0", err_csum_cnt, err_len_cnt, err_to_cnt, drop_cnt); else npass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill_ramp();
        send_frame(8'h01, 8'd16, 1'b0);
        ntot++; if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h01 || pkt_len !== 8'd16)
            $display("FAIL after_midrst got v=%h c=%h l=%h exp v=1 c=01 l=10", pkt_valid, pkt_cmd, pkt_len); else npass++;
        do_ack();
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_bad_csum();
        test_over_len();
        test_hold_drop();
        test_random_frames();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
